// File: rtl/repl_pkg.sv
// Shared types and width helpers for the cache replacement-policy block.
package repl_pkg;

  // Replacement algorithm selected by the MODE parameter.
  typedef enum logic {
    MODE_LRU  = 1'b0,
    MODE_PLRU = 1'b1
  } mode_e;

  // Sweep controller states.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fsm_state_e;

  localparam int DEF_ASSOCIATIVITY = 4;
  localparam int DEF_WAY_BITS      = 2;

  // True-LRU keeps one age of way_bits width per way.
  function automatic int age_state_bits(input int assoc, input int way_bits);
    return assoc * way_bits;
  endfunction

  // Tree pseudo-LRU keeps one direction bit per internal node.
  function automatic int tree_state_bits(input int assoc);
    return assoc - 1;
  endfunction

  // Per-set state width for the selected algorithm.
  function automatic int state_bits(input int assoc, input int way_bits, input int mode);
    if (mode == int'(MODE_PLRU)) begin
      return tree_state_bits(assoc);
    end else begin
      return age_state_bits(assoc, way_bits);
    end
  endfunction

endpackage

// File: rtl/repl_victim_sel.sv
// Combinational victim selection for one set: invalid-and-unlocked ways
// first, then the replacement policy, skipping locked ways.
module repl_victim_sel
  import repl_pkg::*;
#(
  parameter int ASSOCIATIVITY = 4,
  parameter int MODE          = 0,
  localparam int WAY_BITS     = $clog2(ASSOCIATIVITY),
  localparam int STATE_BITS   = state_bits(ASSOCIATIVITY, WAY_BITS, MODE)
) (
  input  logic [STATE_BITS-1:0]    state_i,
  input  logic [ASSOCIATIVITY-1:0] valid_i,
  input  logic [ASSOCIATIVITY-1:0] lock_i,
  output logic [WAY_BITS-1:0]      way_o,
  output logic                     none_o
);

  localparam bit IS_PLRU = (MODE == int'(MODE_PLRU));

  logic                inv_found_s;
  logic [WAY_BITS-1:0] inv_way_s;
  logic [WAY_BITS-1:0] policy_way_s;

  // Lowest-index way that is both invalid and unlocked (descending scan keeps the lowest).
  always_comb begin
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    for (int j = ASSOCIATIVITY - 1; j >= 0; j--) begin
      if (!valid_i[j] && !lock_i[j]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_BITS'(j);
      end else begin
        inv_found_s = inv_found_s;
      end
    end
  end

  if (!IS_PLRU) begin : g_lru
    logic [WAY_BITS-1:0] best_age_s;
    logic                have_s;

    // Unlocked way with the smallest age; strict compare keeps the lowest index on a tie.
    always_comb begin
      policy_way_s = '0;
      best_age_s   = '0;
      have_s       = 1'b0;
      for (int j = 0; j < ASSOCIATIVITY; j++) begin
        if (!lock_i[j] && (!have_s || (state_i[j*WAY_BITS +: WAY_BITS] < best_age_s))) begin
          have_s       = 1'b1;
          best_age_s   = state_i[j*WAY_BITS +: WAY_BITS];
          policy_way_s = WAY_BITS'(j);
        end else begin
          have_s = have_s;
        end
      end
    end
  end else begin : g_plru
    int   prefix_s;
    int   node_s;
    logic dir_s;
    logic sub_locked_s;

    // Tree walk from the root; a node whose pointed subtree is fully locked is overridden.
    always_comb begin
      prefix_s     = 0;
      node_s       = 0;
      dir_s        = 1'b0;
      sub_locked_s = 1'b0;
      for (int l = 0; l < WAY_BITS; l++) begin
        node_s       = (1 << l) - 1 + prefix_s;
        dir_s        = state_i[node_s];
        sub_locked_s = 1'b1;
        for (int j = 0; j < ASSOCIATIVITY; j++) begin
          if ((j >> (WAY_BITS - l - 1)) == ((prefix_s << 1) | int'(dir_s))) begin
            sub_locked_s = sub_locked_s & lock_i[j];
          end else begin
            sub_locked_s = sub_locked_s;
          end
        end
        if (sub_locked_s) begin
          dir_s = ~dir_s;
        end else begin
          dir_s = dir_s;
        end
        prefix_s = (prefix_s << 1) | int'(dir_s);
      end
      policy_way_s = WAY_BITS'(prefix_s);
    end
  end

  // Final priority: all locked, then invalid way, then policy choice.
  always_comb begin
    way_o  = '0;
    none_o = 1'b0;
    if (&lock_i) begin
      none_o = 1'b1;
      way_o  = '0;
    end else if (inv_found_s) begin
      way_o = inv_way_s;
    end else begin
      way_o = policy_way_s;
    end
  end

endmodule

// File: rtl/repl_policy.sv
// Per-set replacement state (true-LRU ages or tree pseudo-LRU) with a
// registered victim port and a sweep that (re)initialises every set.
module repl_policy
  import repl_pkg::*;
#(
  parameter int ASSOCIATIVITY = 4,
  parameter int ENTRIES       = 256,
  parameter int INDEX_BITS    = 8,
  parameter int OUTPUT_BITS   = 2,
  parameter int MODE          = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [INDEX_BITS-1:0]    line_selector,
  input  logic [OUTPUT_BITS-1:0]   referenced_set,
  input  logic                     lru_update,
  input  logic [ASSOCIATIVITY-1:0] valid_mask,
  input  logic [ASSOCIATIVITY-1:0] lock_mask,
  input  logic                     victim_req,
  input  logic                     flush,
  output logic                     victim_valid,
  output logic [OUTPUT_BITS-1:0]   victim_way,
  output logic                     victim_none,
  output logic                     busy
);

  localparam bit IS_PLRU    = (MODE == int'(MODE_PLRU));
  localparam int STATE_BITS = state_bits(ASSOCIATIVITY, OUTPUT_BITS, MODE);
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);

  // State array is deliberately not reset; the sweep initialises it.
  logic [STATE_BITS-1:0] state_mem_q [ENTRIES];

  fsm_state_e              fsm_q, fsm_d;
  logic [INDEX_BITS-1:0]   sweep_idx_q, sweep_idx_d;
  logic                    victim_valid_q;
  logic [OUTPUT_BITS-1:0]  victim_way_q;
  logic                    victim_none_q;

  logic [STATE_BITS-1:0]   rd_state_s;
  logic [STATE_BITS-1:0]   touch_state_s;
  logic [STATE_BITS-1:0]   init_state_s;
  logic                    idle_s;
  logic                    accept_req_s;
  logic                    accept_touch_s;
  logic [OUTPUT_BITS-1:0]  sel_way_s;
  logic                    sel_none_s;

  assign idle_s         = (fsm_q == IDLE);
  assign accept_req_s   = victim_req && idle_s;
  assign accept_touch_s = lru_update && idle_s;
  // Pre-touch read: a same-cycle request sees the state before the touch lands.
  assign rd_state_s     = state_mem_q[line_selector];

  if (!IS_PLRU) begin : g_lru
    logic [OUTPUT_BITS-1:0] old_age_s;
    logic [OUTPUT_BITS-1:0] age_s;

    // Init ages 0..A-1 (way 0 is LRU); touch promotes the way to A-1 and shifts younger ways down.
    always_comb begin
      init_state_s  = '0;
      touch_state_s = '0;
      old_age_s     = rd_state_s[int'(referenced_set)*OUTPUT_BITS +: OUTPUT_BITS];
      age_s         = '0;
      for (int j = 0; j < ASSOCIATIVITY; j++) begin
        init_state_s[j*OUTPUT_BITS +: OUTPUT_BITS] = OUTPUT_BITS'(j);
        age_s = rd_state_s[j*OUTPUT_BITS +: OUTPUT_BITS];
        if (OUTPUT_BITS'(j) == referenced_set) begin
          touch_state_s[j*OUTPUT_BITS +: OUTPUT_BITS] = OUTPUT_BITS'(ASSOCIATIVITY - 1);
        end else if (age_s > old_age_s) begin
          touch_state_s[j*OUTPUT_BITS +: OUTPUT_BITS] = age_s - OUTPUT_BITS'(1);
        end else begin
          touch_state_s[j*OUTPUT_BITS +: OUTPUT_BITS] = age_s;
        end
      end
    end
  end else begin : g_plru
    int node_s;

    // Init clears all tree bits (victim way 0); touch points each path node away from the way.
    always_comb begin
      init_state_s  = '0;
      touch_state_s = rd_state_s;
      node_s        = 0;
      for (int l = 0; l < OUTPUT_BITS; l++) begin
        node_s = (1 << l) - 1 + (int'(referenced_set) >> (OUTPUT_BITS - l));
        touch_state_s[node_s] = ~referenced_set[OUTPUT_BITS-1-l];
      end
    end
  end

  repl_victim_sel #(
    .ASSOCIATIVITY (ASSOCIATIVITY),
    .MODE          (MODE)
  ) u_victim_sel (
    .state_i (rd_state_s),
    .valid_i (valid_mask),
    .lock_i  (lock_mask),
    .way_o   (sel_way_s),
    .none_o  (sel_none_s)
  );

  // Sweep controller next-state: flush always restarts from set 0.
  always_comb begin
    fsm_d       = fsm_q;
    sweep_idx_d = sweep_idx_q;
    case (fsm_q)
      IDLE: begin
        if (flush) begin
          fsm_d       = SWEEP;
          sweep_idx_d = '0;
        end else begin
          fsm_d = IDLE;
        end
      end
      SWEEP: begin
        if (flush) begin
          sweep_idx_d = '0;
        end else if (sweep_idx_q == LAST_IDX) begin
          fsm_d       = IDLE;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + INDEX_BITS'(1);
        end
      end
      default: begin
        fsm_d       = SWEEP;
        sweep_idx_d = '0;
      end
    endcase
  end

  // Sweep controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= SWEEP;
      sweep_idx_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  // State array write port: sweep init has priority over touches.
  always_ff @(posedge clk) begin
    if (fsm_q == SWEEP) begin
      state_mem_q[sweep_idx_q] <= init_state_s;
    end else if (accept_touch_s && rst_n) begin
      state_mem_q[line_selector] <= touch_state_s;
    end
  end

  // Registered victim result, one cycle after an accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_none_q  <= 1'b0;
    end else begin
      victim_valid_q <= accept_req_s;
      victim_way_q   <= accept_req_s ? sel_way_s  : '0;
      victim_none_q  <= accept_req_s ? sel_none_s : 1'b0;
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;
  assign victim_none  = victim_none_q;
  assign busy         = (fsm_q == SWEEP);

endmodule

// File: doc/repl_policy.md
REPL_POLICY -- requirements
Module: repl_policy

Interface
REQ-001 SHALL have parameter ASSOCIATIVITY, default 4: number of ways; power of two, at least 2.
REQ-002 SHALL have parameter ENTRIES, default 256: number of sets tracked.
REQ-003 SHALL have parameter INDEX_BITS, default 8: set index width, equal to $clog2(ENTRIES).
REQ-004 SHALL have parameter OUTPUT_BITS, default 2: way index width, equal to $clog2(ASSOCIATIVITY).
REQ-005 SHALL have parameter MODE, default 0: 0 selects true-LRU age counters, 1 selects tree pseudo-LRU.
REQ-006 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port line_selector  input  INDEX_BITS  set index for the touch and for the victim request.
REQ-009 SHALL have port referenced_set  input  OUTPUT_BITS  way being touched.
REQ-010 SHALL have port lru_update  input  1  touch strobe: mark referenced_set most recently used.
REQ-011 SHALL have port valid_mask  input  ASSOCIATIVITY  per-way valid bits of the indexed set.
REQ-012 SHALL have port lock_mask  input  ASSOCIATIVITY  per-way lock bits; a locked way is never a victim.
REQ-013 SHALL have port victim_req  input  1  request a victim for line_selector.
REQ-014 SHALL have port flush  input  1  pulse that reinitialises every set.
REQ-015 SHALL have port victim_valid  output  1  victim_way and victim_none are valid this cycle.
REQ-016 SHALL have port victim_way  output  OUTPUT_BITS  selected victim way.
REQ-017 SHALL have port victim_none  output  1  all ways locked; victim_way is 0 and meaningless.
REQ-018 SHALL have port busy  output  1  init sweep in progress; touches and requests are ignored.

Function
REQ-019 SHALL keep per-set state: MODE 0 stores ASSOCIATIVITY ages of OUTPUT_BITS each; MODE 1 stores ASSOCIATIVITY-1 tree bits.
REQ-020 SHALL apply a MODE 0 touch as follows: the referenced way's age becomes ASSOCIATIVITY-1; every age greater than the old referenced age decrements; all other ages hold.
REQ-021 SHALL apply a MODE 1 touch by setting every tree node on the referenced way's path to point away from that way.
REQ-022 SHALL commit a touch at the clock edge where lru_update is high and busy is low; the update is visible from the next cycle.
REQ-023 SHALL select the victim in this priority order: lowest-index way that is invalid and unlocked; else, in MODE 0, the unlocked way with the smallest age, lowest index on a tie; else, in MODE 1, a tree walk in which a node whose pointed subtree is fully locked takes the other branch.
REQ-024 SHALL register the victim: a request accepted in cycle N gives victim_valid=1 in cycle N+1 for one cycle, computed from the state and masks sampled in cycle N.
REQ-025 SHALL give, when a touch and a request hit the same set in the same cycle, a victim computed from the pre-touch state.
REQ-026 SHALL accept back-to-back requests every cycle with no bubbles.
REQ-027 SHALL assert victim_none=1 and victim_way=0 together with victim_valid when lock_mask is all ones.
REQ-028 SHALL implement a two-state FSM: SWEEP writes the init pattern to set sweep_idx and increments it each cycle; SWEEP goes to IDLE after set ENTRIES-1 is written; IDLE goes to SWEEP when flush=1, starting from sweep_idx=0.
REQ-029 SHALL use this init pattern: in MODE 0, age[j]=j, so way 0 is the LRU way; in MODE 1, all tree bits 0, so the victim is way 0.
REQ-030 SHALL hold busy=1 exactly while in SWEEP, and SHALL drop lru_update and victim_req in SWEEP without effect and with victim_valid=0.
REQ-031 SHALL restart a sweep from set 0 when flush=1 arrives during SWEEP.
REQ-032 SHALL, when flush=1 arrives with an accepted request in IDLE, still return that request's victim in the next cycle, then enter SWEEP.

Reset
REQ-033 SHALL, while rst_n=0 at a clock edge, drive victim_valid=0, victim_way=0, victim_none=0 and busy=1, and SHALL set the FSM to SWEEP with sweep_idx=0.
REQ-034 SHALL not reset the state array directly; the sweep initialises it over ENTRIES cycles after rst_n rises, including when reset hits mid-sweep or mid-request.

Structure
REQ-035 SHALL place the mode enum (MODE_LRU, MODE_PLRU), the FSM state enum (IDLE, SWEEP) and the age/tree width constants in the shared package repl_pkg.
REQ-036 SHALL put victim selection in a purely combinational sub-module repl_victim_sel, parametrised by ASSOCIATIVITY and MODE.

Verification
REQ-037 SHALL cover reset release: ENTRIES=8 -> busy=1 for 8 cycles, then 0; a request to set 3 -> victim_way=0 one cycle later.
REQ-038 SHALL cover MODE 0 with all valid: touch set 2 with ways 0,1,2 in turn, then request -> victim_way=3; touch 3, then request -> victim_way=0.
REQ-039 SHALL cover invalid priority: valid_mask=4'b1011 with any age state -> victim_way=2; lock_mask=4'b0100 added -> victim_way is the LRU way among 0,1,3.
REQ-040 SHALL cover locks: lock_mask=4'b1111 -> victim_none=1, victim_way=0; in MODE 1 with tree pointing at way 0 and lock_mask=4'b0011 -> victim_way=2.
REQ-041 SHALL cover same-cycle touch and request: touch way 0 of set 5 while requesting set 5 from init -> victim_way=0; the next request -> victim_way=1.
REQ-042 SHALL cover flush mid-sweep: flush at sweep_idx=4 -> sweep restarts at 0, busy stays high 8 more cycles, and a request during SWEEP -> victim_valid=0.
